// File: rtl/cgb_pal_pkg.sv
// Shared definitions for the CGB colour palette file: register map,
// spec-register layout and the power-on colour pattern.
package cgb_pal_pkg;

    localparam logic [15:0] BCPS_ADDR = 16'hFF68;
    localparam logic [15:0] BCPD_ADDR = 16'hFF69;
    localparam logic [15:0] OCPS_ADDR = 16'hFF6A;
    localparam logic [15:0] OCPD_ADDR = 16'hFF6B;

    localparam int AI_BIT = 7;

    localparam logic [15:0] RESET_COL0 = 16'hFFFF;
    localparam logic [15:0] RESET_COL1 = 16'hA514;
    localparam logic [15:0] RESET_COL2 = 16'h630C;
    localparam logic [15:0] RESET_COL3 = 16'h0000;

    // Byte i of a bank after reset; colour number (i/2) mod 4 selects the shade.
    function automatic logic [7:0] reset_byte(input int i);
        logic [15:0] c;
        case ((i >> 1) % 4)
            0:       c = RESET_COL0;
            1:       c = RESET_COL1;
            2:       c = RESET_COL2;
            default: c = RESET_COL3;
        endcase
        return (i % 2 == 1) ? c[15:8] : c[7:0];
    endfunction

endpackage

// File: rtl/cgb_palette_bank.sv
// One palette bank: byte storage, xCPS spec register with auto-increment,
// PPU-lock gating of CPU data access, and a one-cycle colour lookup.
module cgb_palette_bank
    import cgb_pal_pkg::*;
#(
    parameter int          NUM_PAL        = 8,
    parameter int          COLORS_PER_PAL = 4,
    parameter logic [15:0] CPS_ADDR       = BCPS_ADDR,
    parameter logic [15:0] CPD_ADDR       = BCPD_ADDR,
    localparam int         BYTES          = NUM_PAL * COLORS_PER_PAL * 2,
    localparam int         IDX_W          = $clog2(BYTES),
    localparam int         SEL_W          = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int         CI_W           = (COLORS_PER_PAL > 1) ? $clog2(COLORS_PER_PAL) : 1
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic [15:0]      I_MEMBUS_ADDR,
    input  logic [7:0]       I_DATA,
    input  logic             I_MEMBUS_WE_L,
    input  logic             I_PPU_LOCK,
    output logic [7:0]       O_RD_DATA,
    output logic             O_HIT,
    input  logic             I_REQ,
    input  logic [SEL_W-1:0] I_SEL,
    input  logic [CI_W-1:0]  I_INDEX,
    output logic [15:0]      O_COLOR,
    output logic             O_VALID
);

    logic [7:0]       mem [BYTES];
    logic             ai;
    logic [IDX_W-1:0] idx;
    logic             cps_hit, cpd_hit, wr_cps, wr_cpd;
    logic [7:0]       cps_rd;
    logic [IDX_W-1:0] lo_addr, hi_addr;
    int               k;
    logic [15:0]      color_p1;
    logic             vld_p1;

    assign cps_hit = (I_MEMBUS_ADDR == CPS_ADDR);
    assign cpd_hit = (I_MEMBUS_ADDR == CPD_ADDR);
    assign wr_cps  = cps_hit && !I_MEMBUS_WE_L;
    assign wr_cpd  = cpd_hit && !I_MEMBUS_WE_L;
    assign O_HIT   = cps_hit || cpd_hit;

    // Bits not backed by storage (bit 6 and anything above the index) read as 1.
    always_comb begin
        cps_rd            = 8'h7F;
        cps_rd[AI_BIT]    = ai;
        cps_rd[IDX_W-1:0] = idx;
    end

    always_comb begin
        O_RD_DATA = 8'h00;
        if (cps_hit)
            O_RD_DATA = cps_rd;
        else if (cpd_hit)
            O_RD_DATA = I_PPU_LOCK ? 8'hFF : mem[idx];
    end

    always_comb begin
        k       = int'(I_SEL) * COLORS_PER_PAL + int'(I_INDEX);
        lo_addr = IDX_W'(2 * k);
        hi_addr = lo_addr | IDX_W'(1);
    end

    // Stage p1: lookup result; mem is sampled before this edge's CPU write lands.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            ai       <= 1'b0;
            idx      <= '0;
            vld_p1   <= 1'b0;
            color_p1 <= 16'h0000;
            for (int i = 0; i < BYTES; i++)
                mem[i] <= reset_byte(i);
        end else begin
            vld_p1 <= I_REQ;
            if (I_REQ)
                color_p1 <= {mem[hi_addr], mem[lo_addr]};
            if (wr_cps) begin
                ai  <= I_DATA[AI_BIT];
                idx <= I_DATA[IDX_W-1:0];
            end
            if (wr_cpd) begin
                if (!I_PPU_LOCK)
                    mem[idx] <= I_DATA;
                if (ai)
                    idx <= idx + IDX_W'(1);
            end
        end
    end

    assign O_COLOR = color_p1;
    assign O_VALID = vld_p1;

endmodule

// File: rtl/cgb_palette_file.sv
// CGB colour palette file: BG and OBJ palette banks behind the
// BCPS/BCPD/OCPS/OCPD registers, each with its own PPU lookup port.
module cgb_palette_file
    import cgb_pal_pkg::*;
#(
    parameter int  NUM_PAL        = 8,
    parameter int  COLORS_PER_PAL = 4,
    localparam int SEL_W          = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int CI_W           = (COLORS_PER_PAL > 1) ? $clog2(COLORS_PER_PAL) : 1
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic [15:0]      I_MEMBUS_ADDR,
    input  logic [7:0]       I_DATA,
    input  logic             I_MEMBUS_WE_L,
    output logic [7:0]       O_DATA,
    output logic             O_IS_PAL_ADDR,
    input  logic             I_PPU_LOCK,
    input  logic             I_BG_REQ,
    input  logic [SEL_W-1:0] I_BG_SEL,
    input  logic [CI_W-1:0]  I_BG_INDEX,
    output logic [15:0]      O_BG_COLOR,
    output logic             O_BG_VALID,
    input  logic             I_OBJ_REQ,
    input  logic [SEL_W-1:0] I_OBJ_SEL,
    input  logic [CI_W-1:0]  I_OBJ_INDEX,
    output logic [15:0]      O_OBJ_COLOR,
    output logic             O_OBJ_VALID
);

    logic [7:0] bg_rd, obj_rd;
    logic       bg_hit, obj_hit;

    cgb_palette_bank #(
        .NUM_PAL(NUM_PAL), .COLORS_PER_PAL(COLORS_PER_PAL),
        .CPS_ADDR(BCPS_ADDR), .CPD_ADDR(BCPD_ADDR)
    ) u_bg (
        .I_CLK(I_CLK), .I_RESET(I_RESET),
        .I_MEMBUS_ADDR(I_MEMBUS_ADDR), .I_DATA(I_DATA),
        .I_MEMBUS_WE_L(I_MEMBUS_WE_L), .I_PPU_LOCK(I_PPU_LOCK),
        .O_RD_DATA(bg_rd), .O_HIT(bg_hit),
        .I_REQ(I_BG_REQ), .I_SEL(I_BG_SEL), .I_INDEX(I_BG_INDEX),
        .O_COLOR(O_BG_COLOR), .O_VALID(O_BG_VALID)
    );

    cgb_palette_bank #(
        .NUM_PAL(NUM_PAL), .COLORS_PER_PAL(COLORS_PER_PAL),
        .CPS_ADDR(OCPS_ADDR), .CPD_ADDR(OCPD_ADDR)
    ) u_obj (
        .I_CLK(I_CLK), .I_RESET(I_RESET),
        .I_MEMBUS_ADDR(I_MEMBUS_ADDR), .I_DATA(I_DATA),
        .I_MEMBUS_WE_L(I_MEMBUS_WE_L), .I_PPU_LOCK(I_PPU_LOCK),
        .O_RD_DATA(obj_rd), .O_HIT(obj_hit),
        .I_REQ(I_OBJ_REQ), .I_SEL(I_OBJ_SEL), .I_INDEX(I_OBJ_INDEX),
        .O_COLOR(O_OBJ_COLOR), .O_VALID(O_OBJ_VALID)
    );

    assign O_IS_PAL_ADDR = bg_hit || obj_hit;

    always_comb begin
        O_DATA = 8'h00;
        if (bg_hit)
            O_DATA = bg_rd;
        else if (obj_hit)
            O_DATA = obj_rd;
    end

endmodule

// File: tb/tb_cgb_palette_file.sv
// Scoreboard bench for cgb_palette_file: a byte-level model of both banks
// predicts lookup colours; CPU register reads are checked against constants.
module tb_cgb_palette_file;

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b1;
    logic [15:0] I_MEMBUS_ADDR = 16'h0000;
    logic [7:0]  I_DATA = 8'h00;
    logic        I_MEMBUS_WE_L = 1'b1;
    logic [7:0]  O_DATA;
    logic        O_IS_PAL_ADDR;
    logic        I_PPU_LOCK = 1'b0;
    logic        I_BG_REQ = 1'b0;
    logic [2:0]  I_BG_SEL = 3'd0;
    logic [1:0]  I_BG_INDEX = 2'd0;
    logic [15:0] O_BG_COLOR;
    logic        O_BG_VALID;
    logic        I_OBJ_REQ = 1'b0;
    logic [2:0]  I_OBJ_SEL = 3'd0;
    logic [1:0]  I_OBJ_INDEX = 2'd0;
    logic [15:0] O_OBJ_COLOR;
    logic        O_OBJ_VALID;

    cgb_palette_file dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET),
        .I_MEMBUS_ADDR(I_MEMBUS_ADDR), .I_DATA(I_DATA),
        .I_MEMBUS_WE_L(I_MEMBUS_WE_L), .O_DATA(O_DATA),
        .O_IS_PAL_ADDR(O_IS_PAL_ADDR), .I_PPU_LOCK(I_PPU_LOCK),
        .I_BG_REQ(I_BG_REQ), .I_BG_SEL(I_BG_SEL), .I_BG_INDEX(I_BG_INDEX),
        .O_BG_COLOR(O_BG_COLOR), .O_BG_VALID(O_BG_VALID),
        .I_OBJ_REQ(I_OBJ_REQ), .I_OBJ_SEL(I_OBJ_SEL), .I_OBJ_INDEX(I_OBJ_INDEX),
        .O_OBJ_COLOR(O_OBJ_COLOR), .O_OBJ_VALID(O_OBJ_VALID)
    );

    always #5 I_CLK = ~I_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: bank 0 = BG, bank 1 = OBJ
    logic [7:0]  m_mem [2][64];
    logic        m_ai  [2];
    logic [5:0]  m_idx [2];
    logic [15:0] bg_q[$];
    logic [15:0] obj_q[$];

    function automatic logic [15:0] def_color(input int c);
        case (c % 4)
            0:       return 16'hFFFF;
            1:       return 16'hA514;
            2:       return 16'h630C;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_ai[b]  = 1'b0;
            m_idx[b] = 6'd0;
            for (int c = 0; c < 32; c++) begin
                logic [15:0] col;
                col = def_color(c);
                m_mem[b][2*c]   = col[7:0];
                m_mem[b][2*c+1] = col[15:8];
            end
        end
    endtask

    function automatic logic [15:0] model_color(input int b, input int sel, input int ci);
        int k;
        k = sel * 4 + ci;
        return {m_mem[b][2*k+1], m_mem[b][2*k]};
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        int b;
        b = (a == 16'hFF6A || a == 16'hFF6B) ? 1 : 0;
        if (a == 16'hFF68 || a == 16'hFF6A) begin
            m_ai[b]  = d[7];
            m_idx[b] = d[5:0];
        end else if (a == 16'hFF69 || a == 16'hFF6B) begin
            if (!I_PPU_LOCK)
                m_mem[b][m_idx[b]] = d;
            if (m_ai[b])
                m_idx[b] = m_idx[b] + 6'd1;
        end
    endtask

    // Push expectations from the model state before this cycle's write, then clock once.
    task automatic tick();
        if (I_RESET) begin
            model_reset();
        end else begin
            if (I_BG_REQ)
                bg_q.push_back(model_color(0, int'(I_BG_SEL), int'(I_BG_INDEX)));
            if (I_OBJ_REQ)
                obj_q.push_back(model_color(1, int'(I_OBJ_SEL), int'(I_OBJ_INDEX)));
            if (!I_MEMBUS_WE_L)
                model_write(I_MEMBUS_ADDR, I_DATA);
        end
        @(negedge I_CLK);
        I_RESET       = 1'b0;
        I_MEMBUS_WE_L = 1'b1;
        I_BG_REQ      = 1'b0;
        I_OBJ_REQ     = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        I_MEMBUS_ADDR = a;
        I_DATA        = d;
        I_MEMBUS_WE_L = 1'b0;
        tick();
    endtask

    task automatic cpu_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        I_MEMBUS_ADDR = a;
        I_MEMBUS_WE_L = 1'b1;
        #1;
        chk(tag, O_DATA, exp);
        chk({tag, "_ispal"}, O_IS_PAL_ADDR, 1'b1);
    endtask

    task automatic bg_req(input int sel, input int ci);
        I_BG_REQ   = 1'b1;
        I_BG_SEL   = 3'(sel);
        I_BG_INDEX = 2'(ci);
    endtask

    task automatic obj_req(input int sel, input int ci);
        I_OBJ_REQ   = 1'b1;
        I_OBJ_SEL   = 3'(sel);
        I_OBJ_INDEX = 2'(ci);
    endtask

    // Monitor: one edge after a request VALID must rise and the colour must match the queue head.
    logic bg_exp_v, obj_exp_v, rst_seen;
    always @(posedge I_CLK) begin
        bg_exp_v  = I_BG_REQ && !I_RESET;
        obj_exp_v = I_OBJ_REQ && !I_RESET;
        rst_seen  = I_RESET;
        #1;
        chk("bg_valid", O_BG_VALID, bg_exp_v);
        chk("obj_valid", O_OBJ_VALID, obj_exp_v);
        if (bg_exp_v) begin
            chk("bg_q_nonempty", bg_q.size() != 0, 1'b1);
            if (bg_q.size() != 0) chk("bg_color", O_BG_COLOR, bg_q.pop_front());
        end
        if (obj_exp_v) begin
            chk("obj_q_nonempty", obj_q.size() != 0, 1'b1);
            if (obj_q.size() != 0) chk("obj_color", O_OBJ_COLOR, obj_q.pop_front());
        end
        if (rst_seen) begin
            chk("bg_rst_color", O_BG_COLOR, 16'h0000);
            chk("obj_rst_color", O_OBJ_COLOR, 16'h0000);
        end
    end

    initial begin
        model_reset();
        @(negedge I_CLK);
        I_RESET = 1'b1;
        tick();
        cpu_rd("bcps_rst", 16'hFF68, 8'h40);
        cpu_rd("ocps_rst", 16'hFF6A, 8'h40);

        // Default lookup, then idle cycle with colour held
        bg_req(3, 1);
        tick();
        chk("bg_a514", O_BG_COLOR, 16'hA514);
        tick();
        chk("bg_hold", O_BG_COLOR, 16'hA514);

        // Auto-increment writes on BG
        cpu_wr(16'hFF68, 8'h80);
        cpu_wr(16'hFF69, 8'h1F);
        cpu_wr(16'hFF69, 8'h7C);
        cpu_rd("bcps_ai", 16'hFF68, 8'hC2);
        bg_req(0, 0);
        tick();
        chk("bg_7c1f", O_BG_COLOR, 16'h7C1F);

        // OBJ index wrap 63 -> 0
        cpu_wr(16'hFF6A, 8'hBF);
        cpu_wr(16'hFF6B, 8'h11);
        cpu_wr(16'hFF6B, 8'h22);
        cpu_rd("ocps_wrap", 16'hFF6A, 8'hC1);
        obj_req(7, 3);
        tick();
        chk("obj_b63", O_OBJ_COLOR, 16'h1100);
        obj_req(0, 0);
        tick();
        chk("obj_b0", O_OBJ_COLOR, 16'hFF22);

        // Unused spec bits read as 1
        cpu_wr(16'hFF68, 8'h3F);
        cpu_rd("bcps_3f", 16'hFF68, 8'h7F);

        // PPU lock: write dropped, index still advances, reads FFh
        I_PPU_LOCK = 1'b1;
        cpu_wr(16'hFF68, 8'h84);
        cpu_wr(16'hFF69, 8'h55);
        cpu_rd("bcps_lock", 16'hFF68, 8'hC5);
        cpu_rd("bcpd_lock", 16'hFF69, 8'hFF);
        bg_req(0, 2);
        tick();
        chk("bg_lock_lookup", O_BG_COLOR, 16'h630C);
        I_PPU_LOCK = 1'b0;
        cpu_rd("bcpd_unlock", 16'hFF69, 8'h63);
        cpu_rd("bcpd_noinc", 16'hFF68, 8'hC5);

        // Read-before-write on the same byte
        cpu_wr(16'hFF68, 8'h02);
        I_MEMBUS_ADDR = 16'hFF69;
        I_DATA        = 8'h99;
        I_MEMBUS_WE_L = 1'b0;
        bg_req(0, 1);
        tick();
        chk("bg_rbw_old", O_BG_COLOR, 16'hA514);
        bg_req(0, 1);
        tick();
        chk("bg_rbw_new", O_BG_COLOR, 16'hA599);

        // Back-to-back lookups on both banks
        for (int i = 0; i < 12; i++) begin
            bg_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            obj_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            tick();
        end

        // Reset the cycle after an OBJ request, and together with one
        obj_req(5, 2);
        tick();
        chk("obj_pre_rst", O_OBJ_COLOR, 16'h630C);
        I_RESET = 1'b1;
        obj_req(6, 1);
        I_MEMBUS_ADDR = 16'hFF69;
        I_DATA        = 8'hAA;
        I_MEMBUS_WE_L = 1'b0;
        tick();
        chk("obj_rst_valid", O_OBJ_VALID, 1'b0);
        cpu_rd("bcps_after_rst", 16'hFF68, 8'h40);
        bg_req(0, 0);
        obj_req(7, 3);
        tick();
        chk("bg_def", O_BG_COLOR, 16'hFFFF);
        chk("obj_def", O_OBJ_COLOR, 16'h0000);
        bg_req(0, 1);
        obj_req(0, 0);
        tick();
        chk("bg_def_b2", O_BG_COLOR, 16'hA514);
        chk("obj_def_b0", O_OBJ_COLOR, 16'hFFFF);

        // Non-palette address
        I_MEMBUS_ADDR = 16'hFF47;
        #1;
        chk("nonpal_data", O_DATA, 8'h00);
        chk("nonpal_ispal", O_IS_PAL_ADDR, 1'b0);
        I_DATA = 8'h5A;
        I_MEMBUS_WE_L = 1'b0;
        tick();
        cpu_rd("bcps_untouched", 16'hFF68, 8'h40);

        tick();
        chk("bg_q_drained", bg_q.size(), 0);
        chk("obj_q_drained", obj_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
